// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the key debounce controller.
//   - Default parameter values used by the interface, top and channel.
//   - fits_width(): elaboration-time check that a count fits in a counter width.
package key_debounce_pkg;

    localparam int unsigned DefNumKeys    = 4;
    localparam int unsigned DefCntW       = 12;
    localparam int unsigned DefDebounce   = 4095;
    localparam int unsigned DefLongW      = 20;
    localparam int unsigned DefLongCnt    = 500000;
    localparam int unsigned DefRepeatCnt  = 0;
    localparam int unsigned DefActiveHigh = 1;

    // True when value can be represented in an unsigned counter of the given width.
    function automatic bit fits_width(longint unsigned value, int unsigned width);
        if (width >= 64) begin
            return 1'b1;
        end
        return value <= ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/key_debounce_ctrl_if.sv
// Key debounce controller signal bundle.
//   en          : global enable (master -> slave)
//   key_in      : raw key inputs (master -> slave)
//   key_level   : debounced level, 1 = pressed (slave -> master)
//   key_press   : one-cycle accepted-press pulse (slave -> master)
//   key_release : one-cycle accepted-release pulse (slave -> master)
//   key_long    : one-cycle long-press / auto-repeat pulse (slave -> master)
interface key_debounce_ctrl_if
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS = DefNumKeys
);
    logic                en;
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    modport master (
        output en, key_in,
        input  key_level, key_press, key_release, key_long
    );

    modport slave (
        input  en, key_in,
        output key_level, key_press, key_release, key_long
    );
endinterface

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchronizer, debounce counter, hold counter and
// registered press/release/long pulses.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   en_i          : enable; 0 clears both counters and suppresses pulses
//   key_raw_i     : raw asynchronous key input
//   level_o       : debounced level (1 = pressed)
//   press_o       : one-cycle pulse on accepted press
//   release_o     : one-cycle pulse on accepted release
//   long_o        : one-cycle pulse on long press and each auto-repeat
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int unsigned CNT_W        = DefCntW,
    parameter int unsigned DEBOUNCE_CNT = DefDebounce,
    parameter int unsigned LONG_W       = DefLongW,
    parameter int unsigned LONG_CNT     = DefLongCnt,
    parameter int unsigned REPEAT_CNT   = DefRepeatCnt,
    parameter int unsigned ACTIVE_HIGH  = DefActiveHigh
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic en_i,
    input  logic key_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam logic              RawIdle  = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
    localparam logic [CNT_W-1:0]  DbLast   = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [LONG_W-1:0] HoldFire = LONG_W'(LONG_CNT - 1);
    localparam logic [LONG_W-1:0] HoldSat  = LONG_W'(LONG_CNT);
    // Without repeat the counter parks at LONG_CNT, which never re-fires.
    localparam logic [LONG_W-1:0] HoldReload =
        (REPEAT_CNT == 0)        ? HoldSat :
        (REPEAT_CNT < LONG_CNT)  ? LONG_W'(LONG_CNT - REPEAT_CNT) : '0;

    logic              sync1_q, sync2_q;
    logic              act;
    logic              level_q, level_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LONG_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    assign act = (ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;

    always_comb begin
        level_d   = level_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        if (!en_i) begin
            cnt_d  = '0;
            hold_d = '0;
        end else begin
            if (act == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == DbLast) begin
                cnt_d     = '0;
                level_d   = ~level_q;
                press_d   = ~level_q;
                release_d = level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // Press happens while level_q is still 0, so it also clears here.
            if (!level_q || release_d) begin
                hold_d = '0;
            end else if (hold_q == HoldFire) begin
                hold_d = HoldReload;
                long_d = 1'b1;
            end else if (hold_q != HoldSat) begin
                hold_d = hold_q + LONG_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q   <= RawIdle;
            sync2_q   <= RawIdle;
            level_q   <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= key_raw_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_debounce_ctrl.sv
// Multi-key debounce controller: NUM_KEYS independent key_debounce_chan
// instances behind a key_debounce_ctrl_if slave port.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus           : en/key_in in, key_level/key_press/key_release/key_long out
module key_debounce_ctrl
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = DefNumKeys,
    parameter int unsigned CNT_W        = DefCntW,
    parameter int unsigned DEBOUNCE_CNT = DefDebounce,
    parameter int unsigned LONG_W       = DefLongW,
    parameter int unsigned LONG_CNT     = DefLongCnt,
    parameter int unsigned REPEAT_CNT   = DefRepeatCnt,
    parameter int unsigned ACTIVE_HIGH  = DefActiveHigh
) (
    input logic           HCLK,
    input logic           HRESETn,
    key_debounce_ctrl_if.slave bus
);

    if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : gen_bad_num_keys
        $error("key_debounce_ctrl: NUM_KEYS must be 1..32");
    end
    if (DEBOUNCE_CNT == 0 || !fits_width(64'(DEBOUNCE_CNT), CNT_W)) begin : gen_bad_debounce
        $error("key_debounce_ctrl: DEBOUNCE_CNT must be 1..2^CNT_W-1");
    end
    if (LONG_CNT == 0 || !fits_width(64'(LONG_CNT), LONG_W)) begin : gen_bad_long
        $error("key_debounce_ctrl: LONG_CNT must be 1..2^LONG_W-1");
    end
    if (!fits_width(64'(REPEAT_CNT), LONG_W)) begin : gen_bad_repeat
        $error("key_debounce_ctrl: REPEAT_CNT must be < 2^LONG_W");
    end

    logic [NUM_KEYS-1:0] level, press, rel, lng;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : gen_chan
        key_debounce_chan #(
            .CNT_W       (CNT_W),
            .DEBOUNCE_CNT(DEBOUNCE_CNT),
            .LONG_W      (LONG_W),
            .LONG_CNT    (LONG_CNT),
            .REPEAT_CNT  (REPEAT_CNT),
            .ACTIVE_HIGH (ACTIVE_HIGH)
        ) u_chan (
            .HCLK     (HCLK),
            .HRESETn  (HRESETn),
            .en_i     (bus.en),
            .key_raw_i(bus.key_in[i]),
            .level_o  (level[i]),
            .press_o  (press[i]),
            .release_o(rel[i]),
            .long_o   (lng[i])
        );
    end

    assign bus.key_level   = level;
    assign bus.key_press   = press;
    assign bus.key_release = rel;
    assign bus.key_long    = lng;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Self-checking bench for key_debounce_ctrl: directed scenarios with explicit
// latency checks, then randomized key/enable/reset activity compared every
// cycle against a run-length based reference model.
module tb_key_debounce_ctrl;
    import key_debounce_pkg::*;

    localparam int unsigned NK  = 4;
    localparam int unsigned DEB = 8;
    localparam int unsigned LNG = 32;
    localparam int unsigned REP = 10;

    logic HCLK = 1'b0;
    logic HRESETn;

    key_debounce_ctrl_if #(.NUM_KEYS(NK)) bus ();

    key_debounce_ctrl #(
        .NUM_KEYS    (NK),
        .CNT_W       (4),
        .DEBOUNCE_CNT(DEB),
        .LONG_W      (8),
        .LONG_CNT    (LNG),
        .REPEAT_CNT  (REP),
        .ACTIVE_HIGH (1)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // Reference model state: synchronizer delay line, accepted level,
    // run length of "differs from level", and cycles held since press.
    logic [NK-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
    int            m_streak[NK];
    int            m_held[NK];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0;
        m_press = '0; m_rel = '0; m_long = '0;
        for (int k = 0; k < NK; k++) begin
            m_streak[k] = 0;
            m_held[k]   = 0;
        end
    endtask

    task automatic model_edge();
        logic old_level;
        if (!HRESETn) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NK; k++) begin
            old_level  = m_level[k];
            m_press[k] = 1'b0;
            m_rel[k]   = 1'b0;
            m_long[k]  = 1'b0;
            if (!bus.en) begin
                m_streak[k] = 0;
                m_held[k]   = 0;
            end else begin
                m_streak[k] = (m_s2[k] != old_level) ? m_streak[k] + 1 : 0;
                if (m_streak[k] == int'(DEB)) begin
                    m_streak[k] = 0;
                    m_level[k]  = ~old_level;
                    m_press[k]  = ~old_level;
                    m_rel[k]    = old_level;
                end
                if (!old_level || m_rel[k]) begin
                    m_held[k] = 0;
                end else begin
                    m_held[k]++;
                    if (m_held[k] == int'(LNG) ||
                        (REP > 0 && m_held[k] > int'(LNG) && (m_held[k] - int'(LNG)) % int'(REP) == 0))
                        m_long[k] = 1'b1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = bus.key_in;
    endtask

    task automatic compare_all();
        check_eq("key_level",   32'(bus.key_level),   32'(m_level));
        check_eq("key_press",   32'(bus.key_press),   32'(m_press));
        check_eq("key_release", 32'(bus.key_release), 32'(m_rel));
        check_eq("key_long",    32'(bus.key_long),    32'(m_long));
    endtask

    task automatic step();
        @(posedge HCLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic pulse_bit(input int kind, input int ch);
        case (kind)
            0:       return bus.key_press[ch];
            1:       return bus.key_release[ch];
            default: return bus.key_long[ch];
        endcase
    endfunction

    // Steps until the selected DUT pulse appears; n = steps taken, -1 on timeout.
    task automatic wait_pulse(input int kind, input int ch, input int max_steps, output int n);
        n = -1;
        for (int i = 1; i <= max_steps; i++) begin
            step();
            if (pulse_bit(kind, ch)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        model_reset();
        #1;
        check_eq("reset_outputs_zero",
                 32'({bus.key_level, bus.key_press, bus.key_release, bus.key_long}), 32'd0);
        compare_all();
        run(2);
        #2;
        HRESETn = 1'b1;
    endtask

    int n;
    int run_left[NK];
    int en_left;

    initial begin
        HRESETn    = 1'b0;
        bus.en     = 1'b1;
        bus.key_in = '0;
        model_reset();
        #2;
        compare_all();
        run(2);
        HRESETn = 1'b1;
        run(3);

        // Single press: 10 edges to key_press, then release symmetric.
        bus.key_in[0] = 1'b1;
        wait_pulse(0, 0, 20, n);
        check_eq("press0_latency", 32'(n), 32'd10);
        check_eq("level0_after_press", 32'(bus.key_level), 32'b0001);
        bus.key_in[0] = 1'b0;
        wait_pulse(1, 0, 20, n);
        check_eq("release0_latency", 32'(n), 32'd10);
        run(3);

        // Bounce: 7 high, 1 low, then high -> press 10 edges after restart.
        bus.key_in[1] = 1'b1;
        run(7);
        bus.key_in[1] = 1'b0;
        run(1);
        bus.key_in[1] = 1'b1;
        wait_pulse(0, 1, 30, n);
        check_eq("press1_after_bounce", 32'(n), 32'd10);
        bus.key_in[1] = 1'b0;
        run(14);

        // Long press with auto-repeat; release lands on the would-be 4th pulse.
        bus.key_in[2] = 1'b1;
        wait_pulse(0, 2, 20, n);
        check_eq("press2_latency", 32'(n), 32'd10);
        wait_pulse(2, 2, 50, n);
        check_eq("long2_first", 32'(n), 32'(LNG));
        wait_pulse(2, 2, 20, n);
        check_eq("long2_repeat1", 32'(n), 32'(REP));
        wait_pulse(2, 2, 20, n);
        check_eq("long2_repeat2", 32'(n), 32'(REP));
        bus.key_in[2] = 1'b0;
        wait_pulse(2, 2, 30, n);
        check_eq("no_long_after_release", 32'(n), 32'hffff_ffff);
        check_eq("level2_released", 32'(bus.key_level[2]), 32'd0);

        // Simultaneous presses on keys 0 and 3.
        bus.key_in[0] = 1'b1;
        bus.key_in[3] = 1'b1;
        wait_pulse(0, 0, 20, n);
        check_eq("press0_simul", 32'(n), 32'd10);
        check_eq("press3_simul", 32'(bus.key_press[3]), 32'd1);
        bus.key_in[0] = 1'b0;
        bus.key_in[3] = 1'b0;
        run(14);

        // Enable drop mid-qualification forces a full requalification.
        bus.key_in[1] = 1'b1;
        run(7);
        bus.en = 1'b0;
        run(4);
        bus.en = 1'b1;
        wait_pulse(0, 1, 20, n);
        check_eq("press1_requal", 32'(n), 32'(DEB));
        bus.key_in[1] = 1'b0;
        run(14);

        // Reset while key 2 is accepted and still held.
        bus.key_in[2] = 1'b1;
        wait_pulse(0, 2, 20, n);
        check_eq("press2_before_reset", 32'(n), 32'd10);
        run(3);
        do_reset();
        wait_pulse(0, 2, 20, n);
        check_eq("press2_after_reset", 32'(n), 32'd10);
        bus.key_in[2] = 1'b0;
        run(14);

        // Randomized activity against the model.
        for (int k = 0; k < NK; k++) run_left[k] = $urandom_range(1, 20);
        en_left = 100;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (run_left[k] == 0) begin
                    bus.key_in[k] = ~bus.key_in[k];
                    run_left[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 90)
                                                              : $urandom_range(1, 14);
                end else begin
                    run_left[k]--;
                end
            end
            if (en_left == 0) begin
                bus.en  = ~bus.en;
                en_left = bus.en ? $urandom_range(20, 200) : $urandom_range(1, 6);
            end else begin
                en_left--;
            end
            if ($urandom_range(0, 999) == 0) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
